// File: rtl/tt_um_hoene_manchester_encoder.sv
// Manchester line transmitter for the smart-LED chain.
// Accepts words over a valid/ready handshake into a one-word holding register
// and sends frames made of a preamble of '0' bits, back-to-back data words
// (MSB first) and an idle gap with the line held low.
// Bit encoding: '0' = high then low, '1' = low then high, each half HALF_BIT clocks.
// Optional build macro MANCHESTER_ENCODER_PARITY_EN appends one even-parity
// bit after every word.
module tt_um_hoene_manchester_encoder #(
  parameter int DATA_W        = 8,
  parameter int HALF_BIT      = 4,
  parameter int PREAMBLE_BITS = 8,
  parameter int GAP_BITS      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              out,
  output logic              out_clk,
  output logic              busy
);

  // The bit counter covers the longest state: preamble, word (+ parity) or gap.
  localparam int BIT_MAX_A = (PREAMBLE_BITS > DATA_W + 1) ? PREAMBLE_BITS : DATA_W + 1;
  localparam int BIT_MAX   = (BIT_MAX_A > GAP_BITS) ? BIT_MAX_A : GAP_BITS;
  localparam int BIT_W     = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int HALF_W    = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0]  PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  GAP_LAST  = BIT_W'(GAP_BITS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
`ifdef MANCHESTER_ENCODER_PARITY_EN
  localparam logic [2:0] S_PARITY   = 3'd3;
`endif
  localparam logic [2:0] S_GAP      = 3'd4;

  logic [2:0]        state, state_n;
  logic [HALF_W-1:0] half_cnt, half_n;
  logic              phase, phase_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;
  logic              accept;
  logic              load;
  logic              half_end;
  logic              bit_end;
  logic              word_done;
  logic              out_n;
  logic              out_clk_n;
`ifdef MANCHESTER_ENCODER_PARITY_EN
  logic              parity, parity_n;
`endif

  // Line level for one half of a bit: first half is the inverse of the bit.
  function automatic logic line_level(input logic phase_i, input logic bit_i);
    return ~(phase_i ^ bit_i);
  endfunction

  assign tx_ready = ~hold_valid;
  assign busy     = (state != S_IDLE);
  assign accept   = tx_valid & ~hold_valid;
  assign half_end = (half_cnt == HALF_LAST);
  assign bit_end  = half_end & phase;

  // Next-state, counter and shifter logic; every state change restarts the counters.
  always_comb begin
    state_n   = state;
    half_n    = half_cnt;
    phase_n   = phase;
    bit_n     = bit_cnt;
    shift_n   = shift;
    load      = 1'b0;
    word_done = 1'b0;
`ifdef MANCHESTER_ENCODER_PARITY_EN
    parity_n  = parity;
`endif

    if (state != S_IDLE) begin
      if (half_end) begin
        half_n  = '0;
        phase_n = ~phase;
      end else begin
        half_n  = half_cnt + HALF_W'(1);
      end
      if (bit_end) begin
        bit_n = bit_cnt + BIT_W'(1);
        if (state == S_DATA) shift_n = shift << 1;
      end
    end

    case (state)
      S_IDLE: begin
        if (hold_valid) state_n = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        if (bit_end && bit_cnt == PRE_LAST) begin
          state_n = S_DATA;
          load    = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end && bit_cnt == DATA_LAST) begin
`ifdef MANCHESTER_ENCODER_PARITY_EN
          state_n = S_PARITY;
`else
          word_done = 1'b1;
`endif
        end
      end
`ifdef MANCHESTER_ENCODER_PARITY_EN
      S_PARITY: begin
        if (bit_end) word_done = 1'b1;
      end
`endif
      S_GAP: begin
        if (bit_end && bit_cnt == GAP_LAST) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // At a word boundary a waiting word follows with no preamble and no dead cycle.
    if (word_done) begin
      if (hold_valid) begin
        state_n = S_DATA;
        load    = 1'b1;
      end else begin
        state_n = S_GAP;
      end
    end

    if (load) begin
      shift_n = hold_data;
`ifdef MANCHESTER_ENCODER_PARITY_EN
      parity_n = ^hold_data;
`endif
    end

    if (state_n != state || load) begin
      half_n  = '0;
      phase_n = 1'b0;
      bit_n   = '0;
    end
  end

  // Registered outputs are computed from the next position so the line follows the state without lag.
  always_comb begin
    out_n = 1'b0;
    case (state_n)
      S_PREAMBLE: out_n = line_level(phase_n, 1'b0);
      S_DATA:     out_n = line_level(phase_n, shift_n[DATA_W-1]);
`ifdef MANCHESTER_ENCODER_PARITY_EN
      S_PARITY:   out_n = line_level(phase_n, parity_n);
`endif
      default:    out_n = 1'b0;
    endcase
`ifdef MANCHESTER_ENCODER_PARITY_EN
    out_clk_n = (state_n == S_DATA || state_n == S_PARITY) && phase_n && (half_n == '0);
`else
    out_clk_n = (state_n == S_DATA) && phase_n && (half_n == '0);
`endif
  end

  // FSM, counters and shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      half_cnt <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      half_cnt <= half_n;
      phase    <= phase_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
    end
  end

`ifdef MANCHESTER_ENCODER_PARITY_EN
  // Parity of the word currently in the shifter, captured at load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= 1'b0;
    else     parity <= parity_n;
  end
`endif

  // Holding register: filled on handshake, emptied when the shifter takes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (load) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= tx_data;
    end
  end

  // Line and bit-clock output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= 1'b0;
      out_clk <= 1'b0;
    end else begin
      out     <= out_n;
      out_clk <= out_clk_n;
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Scoreboard bench for the Manchester encoder: the driver pushes the expected
// line waveform, words and frame shape for every burst; a negedge monitor pops
// and compares them as the DUT transmits.
`timescale 1ns/1ps
module tb_tt_um_hoene_manchester_encoder;
  localparam int DW = 8;
  localparam int HB = 2;
  localparam int PB = 2;
  localparam int GB = 1;
`ifdef MANCHESTER_ENCODER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WBITS = DW + PAR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, out, out_clk, busy;

  tt_um_hoene_manchester_encoder #(
    .DATA_W(DW), .HALF_BIT(HB), .PREAMBLE_BITS(PB), .GAP_BITS(GB)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .out(out), .out_clk(out_clk), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic          wave_q[$];
  logic [DW-1:0] word_q[$];
  int            len_q[$];
  int            pulse_q[$];
  logic [DW-1:0] burst[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one Manchester bit is HB cycles of ~d then HB cycles of d.
  function automatic void push_bit(input logic d);
    for (int i = 0; i < HB; i++) wave_q.push_back(~d);
    for (int i = 0; i < HB; i++) wave_q.push_back(d);
  endfunction

  task automatic model_frame();
    for (int p = 0; p < PB; p++) push_bit(1'b0);
    foreach (burst[k]) begin
      for (int b = DW - 1; b >= 0; b--) push_bit(burst[k][b]);
      if (PAR != 0) push_bit(^burst[k]);
      word_q.push_back(burst[k]);
    end
    for (int g = 0; g < GB * 2 * HB; g++) wave_q.push_back(1'b0);
    len_q.push_back((PB + burst.size() * WBITS + GB) * 2 * HB);
    pulse_q.push_back(burst.size() * WBITS);
  endtask

  // Monitor state
  int            busy_cnt = 0, pulse_cnt = 0, bit_idx = 0, rec_len = 0, last_len = 0;
  logic [63:0]   rec_wave = '0, last_wave = '0;
  logic [WBITS-1:0] acc = '0;
  logic          prev_out = 1'b0;

  always @(negedge clk) begin
    logic          exp_b, inv_b;
    logic [DW-1:0] exp_w;
    int            exp_i;
    if (!mon_en || rst) begin
      busy_cnt = 0; pulse_cnt = 0; bit_idx = 0; rec_len = 0;
      rec_wave = '0; acc = '0; prev_out = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (out_clk) pulse_cnt++;
        rec_wave = {rec_wave[62:0], out};
        rec_len++;
        if (wave_q.size() == 0) check("wave_overrun", 64'd1, 64'd0);
        else begin
          exp_b = wave_q.pop_front();
          check("line", out, exp_b);
        end
        if (out_clk) begin
          inv_b = ~out;
          check("first_half_inverse", prev_out, inv_b);
          acc = {acc[WBITS-2:0], out};
          bit_idx++;
          if (bit_idx == WBITS) begin
            bit_idx = 0;
            if (word_q.size() == 0) check("word_overrun", 64'd1, 64'd0);
            else begin
              exp_w = word_q.pop_front();
              check("word", acc[WBITS-1 -: DW], exp_w);
`ifdef MANCHESTER_ENCODER_PARITY_EN
              exp_b = ^exp_w;
              check("parity_bit", acc[0], exp_b);
`endif
            end
          end
        end
      end else begin
        check("idle_line", {out, out_clk}, 2'b00);
        if (busy_cnt != 0) begin
          if (len_q.size() == 0) check("frame_overrun", 64'd1, 64'd0);
          else begin
            exp_i = len_q.pop_front();
            check("busy_cycles", busy_cnt, exp_i);
            exp_i = pulse_q.pop_front();
            check("out_clk_pulses", pulse_cnt, exp_i);
          end
          last_wave = rec_wave; last_len = rec_len;
          busy_cnt = 0; pulse_cnt = 0; rec_len = 0; rec_wave = '0; bit_idx = 0;
        end
      end
      prev_out = out;
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    repeat (2) @(negedge clk);
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("idle_timeout", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("wave_q_drained", wave_q.size(), 0);
    check("word_q_drained", word_q.size(), 0);
    check("frame_q_drained", len_q.size(), 0);
  endtask

  // Sends the burst with tx_valid kept high; while the holder is full the data lines carry noise.
  task automatic send_burst();
    int guard;
    model_frame();
    foreach (burst[k]) begin
      guard = 0;
      while (!tx_ready) begin
        tx_valid = 1'b1;
        tx_data  = DW'($urandom);
        @(negedge clk);
        guard++;
        if (guard > 500) begin
          check("ready_timeout", 64'd0, 64'd1);
          tx_valid = 1'b0;
          return;
        end
      end
      tx_valid = 1'b1;
      tx_data  = burst[k];
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, guard, nw;
    // Reset and quiescent outputs
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_out", out, 1'b0);
      check("rst_out_clk", out_clk, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b1);
    end
    mon_en = 1'b1;

    // Single word 0xA5
    burst = {8'hA5};
    send_burst();
`ifdef MANCHESTER_ENCODER_PARITY_EN
    check("a5_len", last_len, 48);
    check("a5_wave", last_wave, 48'b1100_1100_0011_1100_0011_1100_1100_0011_1100_0011_1100_0000);
`else
    check("a5_len", last_len, 44);
    check("a5_wave", last_wave, 44'b1100_1100_0011_1100_0011_1100_1100_0011_1100_0011_0000);
`endif

    // Back-to-back words in one frame
    burst = {8'hFF, 8'h00};
    send_burst();

    // Single 0x01 (parity bit 1 when enabled)
    burst = {8'h01};
    send_burst();

    // Reset mid-word with a second word waiting in the holder
    burst = {8'h3C, 8'h99};
    model_frame();
    tx_valid = 1'b1; tx_data = 8'h3C;
    @(negedge clk);
    cnt = 0; guard = 0;
    tx_valid = 1'b0;
    while (!tx_ready && guard < 200) begin
      @(negedge clk); guard++;
      if (out_clk) cnt++;
    end
    tx_valid = 1'b1; tx_data = 8'h99;
    @(negedge clk);
    tx_valid = 1'b0;
    if (out_clk) cnt++;
    while (cnt < 4 && guard < 200) begin
      @(negedge clk); guard++;
      if (out_clk) cnt++;
    end
    check("reach_bit3", cnt, 4);
    #1 mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_out", out, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_out_clk", out_clk, 1'b0);
    check("async_rst_tx_ready", tx_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wave_q.delete(); word_q.delete(); len_q.delete(); pulse_q.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_out", out, 1'b0);
    end
    mon_en = 1'b1;

    // Randomized bursts
    for (int r = 0; r < 12; r++) begin
      burst.delete();
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) burst.push_back(DW'($urandom));
      send_burst();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
